// File: rtl/test_4bit.sv
// Enable-controlled data register, reference cell for clock-gating insertion.
// Define CLK_GATE_EN to build the latch-based ICG variant instead of the hold mux.
module test_4bit #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             EN,
  output logic [WIDTH-1:0] D_OUT
);

  logic [WIDTH-1:0] d_out_d;
  logic [WIDTH-1:0] d_out_q;

`ifdef CLK_GATE_EN
  logic en_g;
  logic en_latched;
  logic gclk;

  // RST opens the gate too, so reset still lands while EN=0
  assign en_g = EN | RST;

  // Latch closes while CLK=1, so en_g glitches cannot reach gclk
  always_latch begin
    if (!CLK) en_latched = en_g;
  end

  assign gclk = CLK & en_latched;

  always_comb begin
    d_out_d = D_IN;
    if (RST) d_out_d = RST_VAL;
  end

  always_ff @(posedge gclk) begin
    d_out_q <= d_out_d;
  end
`else
  always_comb begin
    d_out_d = d_out_q;
    if (RST) d_out_d = RST_VAL;
    else if (EN) d_out_d = D_IN;
  end

  always_ff @(posedge CLK) begin
    d_out_q <= d_out_d;
  end
`endif

  assign D_OUT = d_out_q;

endmodule

// File: tb/tb_test_4bit.sv
// Randomized and directed check of test_4bit against a behavioural model.
// Inputs change 3 units before each rising edge; outputs checked on falling edges.
module tb_test_4bit;

  localparam int W = 4;
  localparam logic [W-1:0] RV = '0;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;

  logic [W-1:0] exp_v;
  bit           exp_ok;
  int           n_pass;
  int           n_tot;

  test_4bit #(.WIDTH(W), .RST_VAL(RV)) dut (
    .CLK  (clk),
    .RST  (rst),
    .D_IN (d_in),
    .EN   (en),
    .D_OUT(d_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle-by-cycle model compare
  always @(negedge clk) begin
    if (exp_ok) begin
      n_tot++;
      if (d_out === exp_v) n_pass++;
      else $display("FAIL model t=%0t got=%0d exp=%0d", $time, d_out, exp_v);
    end
  end

  // Apply inputs for one edge; model: reset wins, else load, else hold
  task automatic cyc(input bit r, input bit e, input logic [W-1:0] d,
                     input bit glitch = 1'b0);
    rst  = r;
    en   = e;
    d_in = d;
    if (r) begin
      exp_v  = RV;
      exp_ok = 1'b1;
    end else if (e) begin
      exp_v = d;
    end
    if (glitch) begin
      @(posedge clk);
      #1 en = ~en;
      #1 en = ~en;
      #1 d_in = ~d_in;
    end
    @(negedge clk);
    #2;
  endtask

  task automatic lit(input string nm, input logic [W-1:0] want);
    n_tot++;
    if (d_out === want) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", nm, d_out, want);
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    exp_ok = 1'b0;
    exp_v  = '0;
    rst    = 1'b0;
    en     = 1'b0;
    d_in   = '0;
    @(negedge clk);
    #2;

    cyc(1, 0, 4'd0);  lit("reset", 4'd0);
    cyc(0, 1, 4'd1);  lit("load1", 4'd1);
    cyc(0, 0, 4'd0);  lit("hold_a", 4'd1);
    cyc(0, 0, 4'd1);  lit("hold_b", 4'd1);
    cyc(0, 1, 4'd0);  lit("load0", 4'd0);
    cyc(0, 1, 4'd3);  lit("load3", 4'd3);
    cyc(0, 0, 4'd13); lit("hold13", 4'd3);
    cyc(0, 1, 4'd13); lit("load13", 4'd13);
    cyc(0, 1, 4'd13); lit("reload13", 4'd13);
    cyc(0, 1, 4'd15); lit("load15", 4'd15);
    cyc(1, 0, 4'd9);  lit("rst_en0", 4'd0);
    cyc(1, 1, 4'd7);  lit("rst_prio", 4'd0);
    cyc(0, 0, 4'd6, 1'b1); lit("glitch_hold", 4'd0);
    cyc(0, 1, 4'd10, 1'b1); lit("glitch_load", 4'd10);
    cyc(0, 1, 4'd15); lit("all_ones", 4'd15);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 19) == 0),
          ($urandom_range(0, 2) != 0),
          W'($urandom),
          ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, W'($urandom));
    end
    lit("long_hold", exp_v);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
